// File: rtl/rd_capture.sv
// -----------------------------------------------------------------------------
// rd_capture
//   Read-data capture stage behind the read-strobe controller. Every rd strobe
//   samples rdata into a small FIFO; words leave through a valid/ready
//   handshake. If the FIFO cannot take a word, ws is raised for one cycle so
//   the controller re-issues the read, and a saturating retry counter counts
//   the refusal.
//
//   Optional feature macro: RD_CAPTURE_PARITY_EN
//     Adds rpar/perr. Every accepted word with odd parity over {rdata, rpar}
//     sets the sticky perr flag. Without the macro there are no parity ports
//     and no parity logic.
//
// Ports
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   rd         in   read strobe, rdata valid this cycle
//   rdata      in   [DW-1:0] memory read data
//   ws         out  registered wait/retry to the controller
//   out_valid  out  FIFO head valid
//   out_data   out  [DW-1:0] FIFO head word
//   out_ready  in   consumer accepts head
//   count      out  [CW-1:0] occupancy, 0..DEPTH
//   rpar       in   even-parity bit for rdata   (RD_CAPTURE_PARITY_EN only)
//   perr       out  sticky parity error         (RD_CAPTURE_PARITY_EN only)
//   retries    out  [7:0] saturating count of refused strobes
// -----------------------------------------------------------------------------
module rd_capture #(
   parameter int DW    = 8,
   parameter int DEPTH = 4,
   parameter int CW    = $clog2(DEPTH) + 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          rd,
   input  logic [DW-1:0] rdata,
   output logic          ws,
   output logic          out_valid,
   output logic [DW-1:0] out_data,
   input  logic          out_ready,
   output logic [CW-1:0] count,
`ifdef RD_CAPTURE_PARITY_EN
   input  logic          rpar,
   output logic          perr,
`endif
   output logic [7:0]    retries
);

   localparam int AW = $clog2(DEPTH);

   logic [DW-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          pop;
   logic          accept;

   // count alone distinguishes full from empty; the pointers are equal in both.
   assign out_valid = (count != '0);
   assign out_data  = mem[rd_ptr];
   assign pop       = out_valid && out_ready;
   // A full FIFO still accepts when the head leaves on the same edge.
   assign accept    = rd && ((count < CW'(DEPTH)) || pop);

   // Storage and pointers. Pointers wrap naturally because DEPTH is 2**AW.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: storage is a flop array, not a RAM macro, so clearing it in
         // reset is cheap and keeps out_data at a defined 0 after reset.
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register here samples the
         // pre-edge values of pop/accept, independent of statement order.
         if (accept) begin
            mem[wr_ptr] <= rdata;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (pop) rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // Occupancy: simultaneous push and pop leaves it unchanged.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else begin
         case ({accept, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Refusal handling: ws is a one-cycle pulse per refused strobe.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ws      <= 1'b0;
         retries <= '0;
      end else begin
         ws <= rd && !accept;
         if (rd && !accept && (retries != 8'hFF)) retries <= retries + 1'b1;
      end
   end

`ifdef RD_CAPTURE_PARITY_EN
   // Only accepted words are checked; the word is stored regardless.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perr <= 1'b0;
      end else if (accept && (^{rdata, rpar})) begin
         perr <= 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_rd_capture.sv
// -----------------------------------------------------------------------------
// tb_rd_capture
//   Directed self-checking bench for rd_capture (DW=8, DEPTH=4). Inputs are
//   driven 1 ns after a rising edge and outputs are sampled at that time too.
//   Parity checks are compiled in when RD_CAPTURE_PARITY_EN is defined.
// -----------------------------------------------------------------------------
module tb_rd_capture;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       rd;
   logic [7:0] rdata;
   logic       ws;
   logic       out_valid;
   logic [7:0] out_data;
   logic       out_ready;
   logic [2:0] count;
   logic [7:0] retries;
`ifdef RD_CAPTURE_PARITY_EN
   logic       rpar;
   logic       perr;
`endif

   int total = 0;
   int bad   = 0;

   rd_capture #(.DW(8), .DEPTH(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .rd        (rd),
      .rdata     (rdata),
      .ws        (ws),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_ready (out_ready),
      .count     (count),
`ifdef RD_CAPTURE_PARITY_EN
      .rpar      (rpar),
      .perr      (perr),
`endif
      .retries   (retries)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   // Advance to 1 ns after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [7:0] d);
      rd    = 1'b1;
      rdata = d;
      tick();
      rd    = 1'b0;
   endtask

   task automatic drain_expect(input logic [7:0] d, input string tag);
      check(tag, out_data, d);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   int   exp_w;
   int   n_w;
   int   max_cnt;
   logic ws_seen;

   initial begin
      rst_n     = 1'b0;
      rd        = 1'b0;
      rdata     = '0;
      out_ready = 1'b0;
`ifdef RD_CAPTURE_PARITY_EN
      rpar      = 1'b0;
`endif
      #12;
      check("rst_ws", ws, 0);
      check("rst_valid", out_valid, 0);
      check("rst_data", out_data, 0);
      check("rst_count", count, 0);
      check("rst_retries", retries, 0);
`ifdef RD_CAPTURE_PARITY_EN
      check("rst_perr", perr, 0);
`endif
      rst_n = 1'b1;

      // First word after reset
      push(8'hA5);
      check("first_valid", out_valid, 1);
      check("first_data", out_data, 8'hA5);
      check("first_count", count, 1);
      check("first_ws", ws, 0);
      drain_expect(8'hA5, "first_drain");
      check("first_empty", count, 0);

      // Fill and refuse
      for (int i = 1; i <= 5; i++) begin
         rd    = 1'b1;
         rdata = 8'(i);
         tick();
         check($sformatf("fill_ws%0d", i), ws, (i == 5) ? 1 : 0);
      end
      rd = 1'b0;
      check("fill_count", count, 4);
      check("fill_retries", retries, 1);
      tick();
      check("fill_ws_drop", ws, 0);
      for (int i = 1; i <= 4; i++) drain_expect(8'(i), $sformatf("fill_drain%0d", i));
      check("fill_empty", out_valid, 0);

      // Full with simultaneous pop
      for (int i = 0; i < 4; i++) push(8'h21 + 8'(i));
      rd        = 1'b1;
      rdata     = 8'h55;
      out_ready = 1'b1;
      tick();
      rd        = 1'b0;
      out_ready = 1'b0;
      check("fullpop_ws", ws, 0);
      check("fullpop_count", count, 4);
      check("fullpop_retries", retries, 1);
      drain_expect(8'h22, "fullpop_d0");
      drain_expect(8'h23, "fullpop_d1");
      drain_expect(8'h24, "fullpop_d2");
      drain_expect(8'h55, "fullpop_d3");
      check("fullpop_empty", count, 0);

      // Wrap-around stream: 12 words, out_ready toggling 1/0
      exp_w   = 8'h10;
      n_w     = 0;
      max_cnt = 0;
      ws_seen = 1'b0;
      for (int k = 0; k < 24; k++) begin
         out_ready = (k % 2 == 0);
         rd        = (k % 2 == 0) && (n_w < 12);
         rdata     = 8'(8'h10 + n_w);
         if (rd) n_w++;
         if (out_valid && out_ready) begin
            check($sformatf("wrap_w%0d", exp_w - 8'h10), out_data, exp_w);
            exp_w++;
         end
         tick();
         if (ws) ws_seen = 1'b1;
         if (int'(count) > max_cnt) max_cnt = int'(count);
      end
      rd        = 1'b0;
      out_ready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         if (out_valid) begin
            check($sformatf("wrap_w%0d", exp_w - 8'h10), out_data, exp_w);
            exp_w++;
         end
         tick();
      end
      out_ready = 1'b0;
      check("wrap_delivered", exp_w, 8'h1C);
      check("wrap_no_ws", ws_seen, 0);
      check("wrap_max_le4", (max_cnt > 4), 0);

      // Retry counter saturation while full
      for (int i = 0; i < 4; i++) push(8'h31 + 8'(i));
      rd    = 1'b1;
      rdata = 8'hEE;
      for (int i = 0; i < 300; i++) tick();
      rd = 1'b0;
      check("sat_retries", retries, 255);
      check("sat_ws", ws, 1);
      check("sat_count", count, 4);

      // Short reset pulse mid-operation
      #1 rst_n = 1'b0;
      #1;
      check("midrst_ws", ws, 0);
      check("midrst_valid", out_valid, 0);
      check("midrst_count", count, 0);
      check("midrst_retries", retries, 0);
      check("midrst_data", out_data, 0);
      #1 rst_n = 1'b1;
      tick();
      check("postrst_ws", ws, 0);
      check("postrst_count", count, 0);

`ifdef RD_CAPTURE_PARITY_EN
      rpar = 1'b0;
      push(8'h03);
      check("par_ok", perr, 0);
      push(8'h07);
      check("par_err", perr, 1);
      drain_expect(8'h03, "par_d0");
      drain_expect(8'h07, "par_d1");
      check("par_sticky", perr, 1);
      #1 rst_n = 1'b0;
      #1 check("par_rst", perr, 0);
      rst_n = 1'b1;
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
